// File: rtl/instr_mem_loader.sv
// Packs a high-byte-first byte stream into 16-bit words and writes them to instruction memory, holding the CPU meanwhile.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte over all data bytes.
module instr_mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, DONE, ERR, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, DONE, ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              accept;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // mem_addr doubles as the word counter, so the last word is addr == N-1.
  assign last_word = ({1'b0, addr_q} == (len_q - LW'(1)));
  assign accept    = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    byte_ready = (state_q == LEN) || (state_q == HI) || (state_q == LO) || (state_q == CSUM);
    busy       = (state_q == LEN) || (state_q == HI) || (state_q == LO) || (state_q == WR)
                 || (state_q == CSUM);
`else
    byte_ready = (state_q == LEN) || (state_q == HI) || (state_q == LO);
    busy       = (state_q == LEN) || (state_q == HI) || (state_q == LO) || (state_q == WR);
`endif
    mem_we     = (state_q == WR);
    done       = (state_q == DONE);
    err        = (state_q == ERR);
    // An aborted load keeps the CPU held so a partial program never runs.
    cpu_hold   = busy || err;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          if ((byte_data == 8'd0) || (int'(byte_data) > DEPTH)) begin
            state_d = ERR;
          end else begin
            len_d   = LW'(byte_data);
            state_d = HI;
          end
        end
      end
      HI: begin
        if (accept) begin
          wdata_d[DATA_W-1 -: 8] = byte_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + byte_data;
`endif
          state_d = LO;
        end
      end
      LO: begin
        if (accept) begin
          wdata_d[7:0] = byte_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + byte_data;
`endif
          state_d = WR;
        end
      end
      WR: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes, a negedge monitor pops and checks them.
module tb_instr_mem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  instr_mem_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  logic [15:0] tw[16];
  logic        prev_hs = 1'b0;
  logic        prev_we = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endfunction

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
      end
      chk("we_one_after_lo", 32'(prev_hs), 32'd1);
      chk("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_hs <= byte_valid && byte_ready;
    prev_we <= mem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_data  = b;
    byte_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1 for byte %0h", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end_timeout: got done=0 err=0 expected done or err");
    end
  endtask

  task automatic chk_status(input string nm, input logic d, input logic e, input logic h);
    chk({nm, "_done"}, 32'(done), 32'(d));
    chk({nm, "_err"}, 32'(err), 32'(e));
    chk({nm, "_hold"}, 32'(cpu_hold), 32'(h));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_rdy"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic run_load(input string nm, input int n, input bit gaps, input bit poke);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(i), d: tw[i]});
    pulse_start();
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_byte(tw[i][15:8]);
      if (poke && i == 0) begin
        byte_valid = 1'b0;
        pulse_start();
      end
      if (gaps) idle($urandom_range(0, 3));
      send_byte(tw[i][7:0]);
      s = s + tw[i][15:8] + tw[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s);
`endif
    byte_valid = 1'b0;
    wait_end();
    chk_status(nm, 1'b1, 1'b0, 1'b0);
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_bad(input string nm, input logic [7:0] len);
    pulse_start();
    send_byte(len);
    byte_valid = 1'b0;
    wait_end();
    chk_status(nm, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdy", 32'(byte_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    tw[0] = 16'h1234; tw[1] = 16'hABCD; tw[2] = 16'h0001;
    run_load("three", 3, 1'b0, 1'b0);

    run_bad("len00", 8'h00);
    run_bad("len11", 8'h11);

    for (int i = 0; i < 16; i++) tw[i] = 16'(i);
    run_load("full16", 16, 1'b0, 1'b0);
    chk("full16_addr", 32'(mem_addr), 32'hF);

    tw[0] = 16'hBEEF; tw[1] = 16'h5AA5;
    run_load("gaps", 2, 1'b1, 1'b1);

    // Reset after the first write of a 3-word load.
    tw[0] = 16'hC0DE;
    exp_q.push_back('{a: AW'(0), d: 16'hC0DE});
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hC0);
    send_byte(8'hDE);
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    byte_data = 8'h77;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_hold", 32'(cpu_hold), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    chk("mid_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rdy", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk_status("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_pending", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    tw[0] = 16'h1234;
    run_load("csum_ok", 1, 1'b0, 1'b0);
    exp_q.push_back('{a: AW'(0), d: 16'h1234});
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h47);
    byte_valid = 1'b0;
    wait_end();
    chk_status("csum_bad", 1'b0, 1'b1, 1'b1);
    chk("csum_bad_pending", 32'(exp_q.size()), 32'd0);
`endif

    idle(3);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart to the instruction memory's read port: accepts a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU (cpu_hold) while loading, so a new program can be placed without re-synthesising the memory init file.
- Sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
- ADDR_W, 4, instruction memory address width; depth = 2**ADDR_W words.
- DATA_W, 16, instruction word width; fixed at 16 and packed as two bytes.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless the state is IDLE, DONE or ERR.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word write address.
- mem_wdata  out  DATA_W  word to write.
- cpu_hold  out  1  keeps the CPU/PC in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  last load completed without error; sticky until the next start or reset.
- err  out  1  last load aborted; sticky until the next start or reset.

Behaviour:
- A byte transfers in any cycle where byte_valid && byte_ready is true. No combinational path from byte_valid to byte_ready.
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0; state=IDLE.
- cpu_hold is 0 at reset so the preloaded memory image runs unmodified.

State machine:
- IDLE: start -> LEN. On entry to LEN: cpu_hold=1, busy=1, done=0, err=0, word counter cleared, mem_addr=0.
- LEN: byte_ready=1. The accepted byte is N, the number of words to load.
  - N=0 or N>2**ADDR_W -> ERR.
  - Otherwise store N -> HI.
- HI: byte_ready=1. The accepted byte goes to mem_wdata[15:8] -> LO.
- LO: byte_ready=1. The accepted byte goes to mem_wdata[7:0] -> WR.
- WR: byte_ready=0, mem_we=1 for exactly one cycle at the current mem_addr. The write occurs on the edge one cycle after the LO byte is accepted.
  - If this is word N-1 -> DONE (or CSUM when the optional feature is enabled).
  - Otherwise mem_addr+1 -> HI.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0. start -> LEN.
- ERR: err=1, busy=0, cpu_hold stays 1 (a partially loaded program must not run), byte_ready=0. start -> LEN. Only reset or a successful load releases cpu_hold.

Word and address rules:
- Byte order is high byte first.
- mem_addr never wraps during a load. N=2**ADDR_W ends exactly at the last address.

Boundary conditions:
- start asserted in LEN/HI/LO/WR: ignored.
- byte_valid while byte_ready=0: byte is not consumed; the source must hold it.
- Reset mid-load: all outputs and state return to reset values in the next cycle. Words already written stay in memory. No further mem_we is issued.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) covers every accepted HI and LO byte; the length byte is excluded.
  - After the write of word N-1, state CSUM asserts byte_ready=1 and accepts one byte.
  - Byte equals the sum -> DONE; otherwise -> ERR.
  - Words are already written at this point; a mismatch only affects err and cpu_hold.
- Disabled:
  - No CSUM state and no accumulator logic.
  - The write of word N-1 goes directly to DONE.

Test Plan:
- Reset, then idle 5 cycles -> cpu_hold=0, mem_we=0, byte_ready=0, done=0, err=0.
- start; stream 03,12,34,AB,CD,00,01 with byte_valid held high -> writes 1234@0, ABCD@1, 0001@2. Each mem_we lasts 1 cycle, 1 cycle after the LO byte. Then done=1, cpu_hold=0.
- start; length 00 -> err=1, cpu_hold=1, mem_we never asserted. Repeat with length 11 (hex, 17 > 16) -> same result.
- Full load N=10 (hex, 16 words) of values 0000..000F -> addresses 0..F written, mem_addr never wraps, done=1.
- Random byte_valid gaps during a 2-word load -> identical writes; bytes presented while byte_ready=0 are not lost. Pulsing start mid-load has no effect.
- Reset asserted after the first word is written -> no further mem_we, all outputs at reset values.
- With LOADER_CHECKSUM_EN: 01,12,34, then checksum 46 -> done=1. Same load with checksum 47 -> err=1, cpu_hold=1.
